// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings, instruction opcodes
// and the IR capture pattern.
package jtag_pkg;

    // Encodings follow the conventional 1149.1 state codes, so TLR reads 4'hF.
    typedef enum logic [3:0] {
        EXIT2_DR = 4'h0,
        EXIT1_DR = 4'h1,
        SHIFT_DR = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EXIT2_IR = 4'h8,
        EXIT1_IR = 4'h9,
        SHIFT_IR = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_e;

    // Opcodes are zero-extended; the top slices them to IR_WIDTH.
    // BYPASS is all-ones at whatever width is in use.
    localparam logic [31:0] OPC_EXTEST = 32'h0000_0000;
    localparam logic [31:0] OPC_SAMPLE = 32'h0000_0001;
    localparam logic [31:0] OPC_IDCODE = 32'h0000_0002;

    // Alternating pattern, LSBs 01, sliced to IR_WIDTH.
    localparam logic [31:0] IR_CAPTURE = 32'h5555_5555;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register plus TMS-driven next-state logic.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output tap_state_e state
);

    tap_state_e state_next;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state <= TLR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            TLR:      state_next = tms ? TLR      : RTI;
            RTI:      state_next = tms ? SEL_DR   : RTI;
            SEL_DR:   state_next = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_next = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_next = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_next = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_next = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_next = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_next = tms ? SEL_DR   : RTI;
            SEL_IR:   state_next = tms ? TLR      : CAP_IR;
            CAP_IR:   state_next = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_next = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_next = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_next = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_next = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_next = tms ? SEL_DR   : RTI;
            default:  state_next = TLR;
        endcase
    end

endmodule

// File: rtl/jtag_tap_controller.sv
// JTAG TAP controller: instruction decode, IR/bypass/ID registers, TDO mux.
// Define JTAG_IDCODE_EN to include the ID register and IDCODE instruction.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_1001
) (
    input  logic       TCK,
    input  logic       TRST_n,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       BSChainIn,
    output logic       TDO,
    output logic       TDO_en,
    output logic       CaptureDR,
    output logic       ShiftDR,
    output logic       UpdateDR,
    output logic       extest,
    output logic [3:0] TapState
);

    localparam logic [IR_WIDTH-1:0] IR_CAP_W   = IR_CAPTURE[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] OPC_EXT_W  = OPC_EXTEST[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] OPC_SAMP_W = OPC_SAMPLE[IR_WIDTH-1:0];
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] OPC_ID_W    = OPC_IDCODE[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] RESET_INSTR = OPC_ID_W;
    localparam logic [31:0]         ID_VALUE    = {IDCODE_VALUE[31:1], 1'b1};
`else
    localparam logic [IR_WIDTH-1:0] RESET_INSTR = '1;
`endif

    tap_state_e          state;
    logic [IR_WIDTH-1:0] ir_shift;
    logic [IR_WIDTH-1:0] ir_active;
    logic                bypass_reg;
    logic                is_extest;
    logic                is_sample;
    logic                is_idcode;
    logic                bscan_sel;
    logic                dr_lsb;

    jtag_tap_fsm u_fsm (
        .tck    (TCK),
        .trst_n (TRST_n),
        .tms    (TMS),
        .state  (state)
    );

    assign TapState = state;

    // Unlisted opcodes fall through to BYPASS.
    always_comb begin
        is_extest = (ir_active == OPC_EXT_W);
        is_sample = (ir_active == OPC_SAMP_W);
`ifdef JTAG_IDCODE_EN
        is_idcode = (ir_active == OPC_ID_W);
`else
        is_idcode = 1'b0;
`endif
    end

    assign bscan_sel = is_extest | is_sample;
    assign CaptureDR = bscan_sel && (state == CAP_DR);
    assign ShiftDR   = bscan_sel && (state == SHIFT_DR);
    assign UpdateDR  = bscan_sel && (state == UPD_DR);
    // Gated by TLR so extest drops the moment the FSM reaches reset.
    assign extest    = is_extest && (state != TLR);

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            ir_shift <= IR_CAP_W;
        end else if (state == CAP_IR) begin
            ir_shift <= IR_CAP_W;
        end else if (state == SHIFT_IR) begin
            ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        end
    end

    // The active instruction only moves on the falling edge, in UpdIR or TLR.
    always_ff @(negedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            ir_active <= RESET_INSTR;
        end else if (state == TLR) begin
            ir_active <= RESET_INSTR;
        end else if (state == UPD_IR) begin
            ir_active <= ir_shift;
        end
    end

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            bypass_reg <= 1'b0;
        end else if (!bscan_sel && !is_idcode) begin
            if (state == CAP_DR) begin
                bypass_reg <= 1'b0;
            end else if (state == SHIFT_DR) begin
                bypass_reg <= TDI;
            end
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] id_reg;

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            id_reg <= ID_VALUE;
        end else if (is_idcode) begin
            if (state == CAP_DR) begin
                id_reg <= ID_VALUE;
            end else if (state == SHIFT_DR) begin
                id_reg <= {TDI, id_reg[31:1]};
            end
        end
    end
`endif

    always_comb begin
        dr_lsb = bypass_reg;
        if (bscan_sel) begin
            dr_lsb = BSChainIn;
        end
`ifdef JTAG_IDCODE_EN
        else if (is_idcode) begin
            dr_lsb = id_reg[0];
        end
`endif
    end

    // Falling-edge output so the host sees stable data at its next rising edge.
    always_ff @(negedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            TDO    <= 1'b0;
            TDO_en <= 1'b0;
        end else if (state == SHIFT_IR) begin
            TDO    <= ir_shift[0];
            TDO_en <= 1'b1;
        end else if (state == SHIFT_DR) begin
            TDO    <= dr_lsb;
            TDO_en <= 1'b1;
        end else begin
            TDO    <= 1'b0;
            TDO_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller; honours JTAG_IDCODE_EN like the RTL.
module tb_jtag_tap_controller;

    logic       TCK;
    logic       TRST_n;
    logic       TMS;
    logic       TDI;
    logic       BSChainIn;
    logic       TDO;
    logic       TDO_en;
    logic       CaptureDR;
    logic       ShiftDR;
    logic       UpdateDR;
    logic       extest;
    logic [3:0] TapState;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_pulses = 0;
    logic exp_q[$];

    jtag_tap_controller dut (
        .TCK       (TCK),
        .TRST_n    (TRST_n),
        .TMS       (TMS),
        .TDI       (TDI),
        .BSChainIn (BSChainIn),
        .TDO       (TDO),
        .TDO_en    (TDO_en),
        .CaptureDR (CaptureDR),
        .ShiftDR   (ShiftDR),
        .UpdateDR  (UpdateDR),
        .extest    (extest),
        .TapState  (TapState)
    );

    // clock / reset
    initial begin
        TCK = 1'b0;
        forever #5 TCK = ~TCK;
    end

    always @(posedge UpdateDR) upd_pulses++;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // driver tasks: inputs change at negedge+1, outputs sampled there too
    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge TCK);
        #1;
        TRST_n = 1'b0;
        @(negedge TCK);
        #1;
        TRST_n = 1'b1;
    endtask

    // from RTI, shift an opcode into IR and return to RTI
    task automatic load_ir(input logic [3:0] opc);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(i == 3, opc[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        TRST_n = 1'b0;
        #1;
        n_checks++;
        if (TapState !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_state: got %h want f", TapState);
        end
        n_checks++;
        if ({TDO, TDO_en, extest} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_tdo: got tdo/en/extest=%b want 000", {TDO, TDO_en, extest});
        end
        n_checks++;
        if ({CaptureDR, ShiftDR, UpdateDR} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 000", {CaptureDR, ShiftDR, UpdateDR});
        end
        @(negedge TCK);
        #1;
        TRST_n = 1'b1;
    endtask

    task automatic test_tlr_from_all();
        logic [3:0] codes [16];
        logic [7:0] paths [16];
        int         lens  [16];
        codes = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                  4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
        // TMS bits applied LSB first from TLR
        paths = '{8'b0000000, 8'b0000000, 8'b0000010, 8'b0000010, 8'b0000010,
                  8'b0001010, 8'b0001010, 8'b0101010, 8'b0011010, 8'b0000110,
                  8'b0000110, 8'b0000110, 8'b0010110, 8'b0010110, 8'b1010110,
                  8'b0110110};
        lens  = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
        for (int s = 0; s < 16; s++) begin
            do_reset();
            for (int b = 0; b < lens[s]; b++) step(paths[s][b], 1'b0);
            n_checks++;
            if (TapState !== codes[s]) begin
                n_fail++;
                $display("FAIL walk_state_%0d: got %h want %h", s, TapState, codes[s]);
            end
            for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
            n_checks++;
            if (TapState !== 4'hF) begin
                n_fail++;
                $display("FAIL tlr_from_%0d: got %h want f", s, TapState);
            end
        end
    endtask

    task automatic test_ir_capture();
        do_reset();
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            logic e;
            e = exp_q.pop_front();
            n_checks++;
            if (TDO !== e || TDO_en !== 1'b1) begin
                n_fail++;
                $display("FAIL ir_capture_bit%0d: got tdo=%b en=%b want tdo=%b en=1", i, TDO, TDO_en, e);
            end
            step(i == 3, 1'b0);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        // all-zero IR shifted in is EXTEST
        n_checks++;
        if (extest !== 1'b1) begin
            n_fail++;
            $display("FAIL ir_update_extest: got %b want 1", extest);
        end
    endtask

    task automatic test_idcode_after_reset();
        logic [31:0] id_exp;
        id_exp = 32'h0000_1001;
        do_reset();
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
`ifdef JTAG_IDCODE_EN
        for (int i = 0; i < 32; i++) exp_q.push_back(id_exp[i]);
        for (int i = 0; i < 32; i++) begin
            logic e;
            e = exp_q.pop_front();
            n_checks++;
            if (TDO !== e) begin
                n_fail++;
                $display("FAIL idcode_bit%0d: got %b want %b", i, TDO, e);
            end
            if (i == 15) begin
                // detour through Pause; DR contents must survive
                step(1'b1, 1'($urandom_range(0, 1)));
                step(1'b0, 1'b0);
                step(1'b0, 1'b0);
                n_checks++;
                if (TDO_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pause_tdo_en: got %b want 0", TDO_en);
                end
                step(1'b1, 1'b0);
                step(1'b0, 1'b0);
            end else begin
                step(i == 31, 1'($urandom_range(0, 1)));
            end
        end
`else
        n_checks++;
        if (TDO !== 1'b0 || TDO_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_dr_bypass: got tdo=%b en=%b want tdo=0 en=1", TDO, TDO_en);
        end
        step(1'b0, 1'b1);
        n_checks++;
        if (TDO !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_dr_bypass_delay: got %b want 1", TDO);
        end
        step(1'b1, 1'b0);
`endif
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        logic [3:0] tdi_v;
        tdi_v = 4'b1101;
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        step(1'b0, 1'b0);
        load_ir(4'b1111);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            logic e;
            e = exp_q.pop_front();
            n_checks++;
            if (TDO !== e || ShiftDR !== 1'b0) begin
                n_fail++;
                $display("FAIL bypass_bit%0d: got tdo=%b shiftdr=%b want tdo=%b shiftdr=0", i, TDO, ShiftDR, e);
            end
            step(i == 3, tdi_v[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_idcode_opcode();
        do_reset();
        step(1'b0, 1'b0);
        load_ir(4'b0010);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
`ifdef JTAG_IDCODE_EN
        n_checks++;
        if (TDO !== 1'b1) begin
            n_fail++;
            $display("FAIL idcode_opcode_lsb: got %b want 1", TDO);
        end
`else
        n_checks++;
        if (TDO !== 1'b0) begin
            n_fail++;
            $display("FAIL idcode_as_bypass: got %b want 0", TDO);
        end
        step(1'b0, 1'b1);
        n_checks++;
        if (TDO !== 1'b1) begin
            n_fail++;
            $display("FAIL idcode_as_bypass_delay: got %b want 1", TDO);
        end
`endif
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_extest();
        logic [7:0] tms_v;
        logic [7:0] bs_v;
        int cap_n;
        int sh_n;
        int up_n;
        tms_v = 8'b01100001;
        bs_v  = 8'b00010100;
        cap_n = 0;
        sh_n  = 0;
        up_n  = 0;
        do_reset();
        step(1'b0, 1'b0);
        load_ir(4'b0000);
        n_checks++;
        if (extest !== 1'b1) begin
            n_fail++;
            $display("FAIL extest_flag: got %b want 1", extest);
        end
        for (int i = 0; i < 8; i++) begin
            BSChainIn = bs_v[i];
            step(tms_v[i], 1'b0);
            if (CaptureDR === 1'b1) cap_n++;
            if (UpdateDR === 1'b1) up_n++;
            if (ShiftDR === 1'b1) begin
                sh_n++;
                n_checks++;
                if (TDO !== bs_v[i] || TDO_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL extest_tdo_%0d: got tdo=%b en=%b want tdo=%b en=1", i, TDO, TDO_en, bs_v[i]);
                end
            end
        end
        n_checks++;
        if (cap_n !== 1 || sh_n !== 3 || up_n !== 1) begin
            n_fail++;
            $display("FAIL extest_ctl_counts: got cap=%0d sh=%0d up=%0d want 1 3 1", cap_n, sh_n, up_n);
        end
        BSChainIn = 1'b0;
    endtask

    task automatic test_sample();
        do_reset();
        step(1'b0, 1'b0);
        load_ir(4'b0001);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_checks++;
        if (CaptureDR !== 1'b1 || extest !== 1'b0) begin
            n_fail++;
            $display("FAIL sample_capture: got cap=%b extest=%b want 1 0", CaptureDR, extest);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_checks++;
        if (UpdateDR !== 1'b1) begin
            n_fail++;
            $display("FAIL sample_update: got %b want 1", UpdateDR);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        int upd_before;
        do_reset();
        step(1'b0, 1'b0);
        load_ir(4'b0000);
        BSChainIn = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        n_checks++;
        if (TDO_en !== 1'b1 || TapState !== 4'h2) begin
            n_fail++;
            $display("FAIL abort_pre: got en=%b state=%h want 1 2", TDO_en, TapState);
        end
        upd_before = upd_pulses;
        TRST_n = 1'b0;
        #1;
        n_checks++;
        if (TapState !== 4'hF || extest !== 1'b0 || TDO_en !== 1'b0 || TDO !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_immediate: got state=%h extest=%b en=%b tdo=%b want f 0 0 0",
                     TapState, extest, TDO_en, TDO);
        end
        @(negedge TCK);
        #1;
        TRST_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        n_checks++;
        if (upd_pulses !== upd_before || extest !== 1'b0 || TapState !== 4'hF) begin
            n_fail++;
            $display("FAIL abort_no_update: got pulses=%0d extest=%b state=%h want %0d 0 f",
                     upd_pulses, extest, TapState, upd_before);
        end
        BSChainIn = 1'b0;
    endtask

    initial begin
        TRST_n    = 1'b0;
        TMS       = 1'b1;
        TDI       = 1'b0;
        BSChainIn = 1'b0;
        @(negedge TCK);
        #1;
        TRST_n = 1'b1;
        test_reset();
        test_tlr_from_all();
        test_ir_capture();
        test_idcode_after_reset();
        test_bypass();
        test_idcode_opcode();
        test_extest();
        test_sample();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
